// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder/table/ROM-facing signal bundle of the program-counter sequencer.
interface pc_sequencer_if #(
   parameter int PC_W  = 12,
   parameter int LA_W  = 5,
   parameter int CYC_W = 16
);
   logic             Start;
   logic [PC_W-1:0]  StartPc;
   logic             Stall;
   logic             BranchEn;
   logic [LA_W-1:0]  BranchSel;
   logic             HaltEn;
   logic [LA_W-1:0]  LutAddr;
   logic [PC_W-1:0]  LutTarget;
   logic [PC_W-1:0]  ProgCtr;
   logic             Running;
   logic             Done;
   logic             Fault;
   logic [CYC_W-1:0] CycleCnt;
   modport master (
      output Start, StartPc, Stall, BranchEn, BranchSel, HaltEn, LutTarget,
      input  LutAddr, ProgCtr, Running, Done, Fault, CycleCnt
   );
   modport slave (
      input  Start, StartPc, Stall, BranchEn, BranchSel, HaltEn, LutTarget,
      output LutAddr, ProgCtr, Running, Done, Fault, CycleCnt
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: holds the PC, looks up branch targets through the label table,
// and reports halt/fault/cycle count for the running program.
module pc_sequencer #(
   parameter int          PC_W       = 12,
   parameter int          LA_W       = 5,
   parameter int unsigned NUM_LABELS = 18,
   parameter int          CYC_W      = 16
) (
   input logic            Clk,
   input logic            Reset_n,
   pc_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nxt;
   logic [PC_W-1:0]  pc, pc_nxt;
   logic [CYC_W-1:0] cnt, cnt_nxt;
   logic             done, done_nxt, fault, fault_nxt, label_ok;
   assign label_ok      = 32'(bus.BranchSel) < NUM_LABELS;
   assign bus.LutAddr   = bus.BranchSel;
   assign bus.ProgCtr   = pc;
   assign bus.Running   = state == RUN;
   assign bus.Done      = done;
   assign bus.Fault     = fault;
   assign bus.CycleCnt  = cnt;
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         state <= IDLE;
         pc    <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         fault <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         cnt   <= cnt_nxt;
         done  <= done_nxt;
         fault <= fault_nxt;
      end
   // Stall outranks everything, so a stalled halt is simply retried next cycle.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      cnt_nxt   = cnt;
      done_nxt  = done;
      fault_nxt = fault;
      if (state != RUN) begin
         if (bus.Start) begin
            state_nxt = RUN;
            pc_nxt    = bus.StartPc;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            fault_nxt = 1'b0;
         end
      end else begin
         cnt_nxt = &cnt ? cnt : cnt + CYC_W'(1);
         if (!bus.Stall) begin
            if (bus.HaltEn) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end else if (bus.BranchEn && label_ok)
               pc_nxt = bus.LutTarget;
            else if (bus.BranchEn || &pc) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
               fault_nxt = 1'b1;
            end else
               pc_nxt = pc + PC_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; a behavioural model pushes expected state per cycle.
module tb_pc_sequencer;
   logic Clk, Reset_n;
   int   n_chk, n_pass;
   pc_sequencer_if #(.PC_W(12), .LA_W(5), .CYC_W(16)) bus ();
   pc_sequencer_if #(.PC_W(12), .LA_W(5), .CYC_W(4))  bus4 ();
   pc_sequencer #(.PC_W(12), .LA_W(5), .NUM_LABELS(18), .CYC_W(16)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
   );
   pc_sequencer #(.PC_W(12), .LA_W(5), .NUM_LABELS(18), .CYC_W(4)) dut4 (
      .Clk(Clk), .Reset_n(Reset_n), .bus(bus4)
   );
   typedef struct {
      logic [11:0] pc;
      logic        run, done, fault;
      logic [15:0] cnt;
   } exp_t;
   exp_t        sb[$];
   logic        m_run, m_done, m_fault;
   logic [11:0] m_pc;
   logic [15:0] m_cnt;
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   task automatic model_reset();
      m_run = 0; m_done = 0; m_fault = 0; m_pc = 0; m_cnt = 0;
   endtask
   // Called at posedge+1: drive one cycle, predict, then compare after the edge.
   task automatic step(input logic st, input logic [11:0] spc, input logic stl, input logic br,
                       input logic [4:0] sel, input logic hlt, input logic [11:0] tgt);
      exp_t e, g;
      bus.Start = st; bus.StartPc = spc; bus.Stall = stl;
      bus.BranchEn = br; bus.BranchSel = sel; bus.HaltEn = hlt; bus.LutTarget = tgt;
      if (!m_run) begin
         if (st) begin
            m_run = 1; m_pc = spc; m_cnt = 0; m_done = 0; m_fault = 0;
         end
      end else begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
         if (stl) ;
         else if (hlt) begin m_run = 0; m_done = 1; end
         else if (br && sel < 18) m_pc = tgt;
         else if (br || m_pc == 12'hFFF) begin m_run = 0; m_done = 1; m_fault = 1; end
         else m_pc = m_pc + 1;
      end
      e.pc = m_pc; e.run = m_run; e.done = m_done; e.fault = m_fault; e.cnt = m_cnt;
      sb.push_back(e);
      #1 check("lut_addr", 32'(bus.LutAddr), 32'(sel));
      @(posedge Clk);
      #1;
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else begin
         g = sb.pop_front();
         check("pc", 32'(bus.ProgCtr), 32'(g.pc));
         check("running", 32'(bus.Running), 32'(g.run));
         check("done", 32'(bus.Done), 32'(g.done));
         check("fault", 32'(bus.Fault), 32'(g.fault));
         check("cycle_cnt", 32'(bus.CycleCnt), 32'(g.cnt));
      end
   endtask
   task automatic plain();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      n_chk = 0; n_pass = 0;
      model_reset();
      Reset_n = 0;
      bus.Start = 0; bus.StartPc = 0; bus.Stall = 0; bus.BranchEn = 0;
      bus.BranchSel = 0; bus.HaltEn = 0; bus.LutTarget = 0;
      bus4.Start = 0; bus4.StartPc = 0; bus4.Stall = 0; bus4.BranchEn = 0;
      bus4.BranchSel = 0; bus4.HaltEn = 0; bus4.LutTarget = 0;
      #2;
      check("rst_pc", 32'(bus.ProgCtr), 0);
      check("rst_running", 32'(bus.Running), 0);
      check("rst_done", 32'(bus.Done), 0);
      check("rst_fault", 32'(bus.Fault), 0);
      check("rst_cnt", 32'(bus.CycleCnt), 0);
      #10 Reset_n = 1;
      @(posedge Clk); #1;
      // Narrow counter saturation on the second instance
      bus4.Start = 1;
      @(posedge Clk); #1;
      bus4.Start = 0;
      for (int i = 0; i < 14; i++) begin @(posedge Clk); #1; end
      check("sat4_cnt14", 32'(bus4.CycleCnt), 14);
      for (int i = 0; i < 6; i++) begin @(posedge Clk); #1; end
      check("sat4_cnt20", 32'(bus4.CycleCnt), 15);
      check("sat4_running", 32'(bus4.Running), 1);
      // Linear run 4..14 then halt
      step(1, 4, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) plain();
      step(0, 0, 0, 0, 0, 1, 0);
      check("lin_cnt", 32'(bus.CycleCnt), 11);
      check("lin_pc", 32'(bus.ProgCtr), 14);
      step(0, 0, 1, 1, 3, 1, 77);
      // Branch through label 2
      step(1, 10, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 2, 0, 351);
      check("br_pc", 32'(bus.ProgCtr), 351);
      plain();
      check("br_pc_next", 32'(bus.ProgCtr), 352);
      step(0, 0, 0, 1, 17, 0, 352);
      step(0, 0, 0, 0, 0, 1, 0);
      // Bad labels 18 and 31
      step(1, 20, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 18, 0, 500);
      check("bad18_fault", 32'(bus.Fault), 1);
      check("bad18_pc", 32'(bus.ProgCtr), 20);
      step(1, 20, 0, 0, 0, 0, 0);
      check("restart_fault", 32'(bus.Fault), 0);
      step(0, 0, 0, 1, 31, 0, 500);
      check("bad31_done", 32'(bus.Done), 1);
      // Priority cases
      step(1, 7, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1, 0);
      check("stall_halt_run", 32'(bus.Running), 1);
      step(0, 0, 0, 0, 0, 1, 0);
      step(1, 50, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 2, 1, 900);
      check("halt_br_pc", 32'(bus.ProgCtr), 50);
      // Start ignored in RUN, stalls still count
      step(1, 30, 0, 0, 0, 0, 0);
      plain();
      step(1, 99, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      check("start_in_run_pc", 32'(bus.ProgCtr), 32);
      step(0, 0, 0, 0, 0, 1, 0);
      // Overrun at the top of the address space
      step(1, 4094, 0, 0, 0, 0, 0);
      plain();
      plain();
      check("ovr_pc", 32'(bus.ProgCtr), 4095);
      check("ovr_fault", 32'(bus.Fault), 1);
      // Reset mid-RUN at PC=37
      step(1, 35, 0, 0, 0, 0, 0);
      plain();
      plain();
      Reset_n = 0;
      #1;
      model_reset();
      check("mid_rst_pc", 32'(bus.ProgCtr), 0);
      check("mid_rst_running", 32'(bus.Running), 0);
      check("mid_rst_done", 32'(bus.Done), 0);
      check("mid_rst_cnt", 32'(bus.CycleCnt), 0);
      #2 Reset_n = 1;
      @(posedge Clk); #1;
      plain();
      step(1, 5, 0, 0, 0, 0, 0);
      plain();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
